// File: rtl/addru_pkg.sv
// Shared types and constants for the residue-checked adder.
// ADDRU_FAULT_INJ_EN (top level) adds the fi_mask fault-injection port.
package addru_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        CHECK   = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef logic [1:0] res_t;

    localparam int RETRY_W  = 4;
    localparam int ERRCNT_W = 8;

    // Both operands are canonical residues (0..2), so one subtraction is enough.
    function automatic res_t add_mod3(input res_t a, input res_t b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

endpackage

// File: rtl/addru_mod3.sv
// Combinational mod-3 residue of a W-bit unsigned value.
// Even bit positions weigh 1 and odd positions weigh 2, because 2^k mod 3 alternates 1,2.
module addru_mod3
    import addru_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    output res_t         r
);

    res_t acc;

    always_comb begin
        acc = 2'd0;
        for (int i = 0; i < W; i++) begin
            if (x[i]) acc = add_mod3(acc, (i % 2 == 1) ? 2'd2 : 2'd1);
        end
    end

    assign r = acc;

endmodule

// File: rtl/addru_rc_pipe.sv
// WIDTH-bit adder with mod-3 residue check, bounded recompute and error reporting.
// Define ADDRU_FAULT_INJ_EN to add the fi_mask port that corrupts sum_q on each COMPUTE.
module addru_rc_pipe
    import addru_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
`ifdef ADDRU_FAULT_INJ_EN
    input  logic [WIDTH:0]      fi_mask,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH:0]      out_sum,
    output logic                out_err,
    output logic [RETRY_W-1:0]  out_retries,
    output logic [ERRCNT_W-1:0] err_count
);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [WIDTH:0]       sum_q, sum_d;
    logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic [ERRCNT_W-1:0]  err_count_q, err_count_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH:0]       out_sum_q, out_sum_d;
    logic                 out_err_q, out_err_d;
    logic [RETRY_W-1:0]   out_retries_q, out_retries_d;

    logic [WIDTH:0]       mask;
    res_t                 r_a, r_b, r_sum;
    logic                 res_ok;

`ifdef ADDRU_FAULT_INJ_EN
    assign mask = fi_mask;
`else
    assign mask = '0;
`endif

    addru_mod3 #(.W(WIDTH))   u_mod3_a   (.x(a_q),   .r(r_a));
    addru_mod3 #(.W(WIDTH))   u_mod3_b   (.x(b_q),   .r(r_b));
    addru_mod3 #(.W(WIDTH+1)) u_mod3_sum (.x(sum_q), .r(r_sum));

    assign res_ok = (r_sum == add_mod3(r_a, r_b));

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        sum_d         = sum_q;
        retry_cnt_d   = retry_cnt_q;
        err_count_d   = err_count_q;
        out_valid_d   = out_valid_q;
        out_sum_d     = out_sum_q;
        out_err_d     = out_err_q;
        out_retries_d = out_retries_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d         = in_a;
                    b_d         = in_b;
                    retry_cnt_d = '0;
                    state_d     = COMPUTE;
                end
            end
            COMPUTE: begin
                sum_d   = ({1'b0, a_q} + {1'b0, b_q}) ^ mask;
                state_d = CHECK;
            end
            CHECK: begin
                if (res_ok) begin
                    out_err_d     = 1'b0;
                    out_sum_d     = sum_q;
                    out_retries_d = retry_cnt_q;
                    out_valid_d   = 1'b1;
                    state_d       = DONE;
                end else begin
                    if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
                    if (retry_cnt_q < RETRY_W'(MAX_RETRY)) begin
                        retry_cnt_d = retry_cnt_q + 1'b1;
                        state_d     = COMPUTE;
                    end else begin
                        out_err_d     = 1'b1;
                        out_sum_d     = sum_q;
                        out_retries_d = retry_cnt_q;
                        out_valid_d   = 1'b1;
                        state_d       = DONE;
                    end
                end
            end
            DONE: begin
                // Result registers stay put; only valid drops on the handshake.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            sum_q         <= '0;
            retry_cnt_q   <= '0;
            err_count_q   <= '0;
            out_valid_q   <= 1'b0;
            out_sum_q     <= '0;
            out_err_q     <= 1'b0;
            out_retries_q <= '0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            sum_q         <= sum_d;
            retry_cnt_q   <= retry_cnt_d;
            err_count_q   <= err_count_d;
            out_valid_q   <= out_valid_d;
            out_sum_q     <= out_sum_d;
            out_err_q     <= out_err_d;
            out_retries_q <= out_retries_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign out_sum     = out_sum_q;
    assign out_err     = out_err_q;
    assign out_retries = out_retries_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_addru_rc_pipe.sv
// Scoreboard bench for addru_rc_pipe (WIDTH=8, MAX_RETRY=2).
// Fault-injection cases run only when ADDRU_FAULT_INJ_EN is defined.
module tb_addru_rc_pipe;

    typedef struct {
        logic [8:0] sum;
        logic       err;
        logic [3:0] retries;
        int         lat;
        int         mism;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a, in_b;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_sum;
    logic       out_err;
    logic [3:0] out_retries;
    logic [7:0] err_count;
`ifdef ADDRU_FAULT_INJ_EN
    logic [8:0] fi_mask;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   exp_errcnt = 0;
    exp_t sb[$];

    addru_rc_pipe #(.WIDTH(8), .MAX_RETRY(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
`ifdef ADDRU_FAULT_INJ_EN
        .fi_mask(fi_mask),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_err(out_err),
        .out_retries(out_retries), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t clean(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.sum = {1'b0, a} + {1'b0, b};
        e.err = 1'b0;
        e.retries = 4'd0;
        e.lat = 3;
        e.mism = 0;
        return e;
    endfunction

    // m0 applies to the first COMPUTE edge, m1 to every later one.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                           input logic [8:0] m0, input logic [8:0] m1,
                           input int hold, input exp_t e);
        exp_t got;
        int   lat;
        logic [8:0] unused_m;
        unused_m = m0 ^ m1;
        sb.push_back(e);
        exp_errcnt = (exp_errcnt + e.mism > 255) ? 255 : exp_errcnt + e.mism;
`ifdef ADDRU_FAULT_INJ_EN
        fi_mask = m0;
`endif
        out_ready = (hold == 0);
        in_a = a; in_b = b; in_valid = 1'b1;
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
`ifdef ADDRU_FAULT_INJ_EN
            if (lat == 2) fi_mask = m1;
`endif
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 32'(out_valid), 32'd1);
            sb.delete();
            out_ready = 1'b1;
            return;
        end
        got = sb.pop_front();
        chk("out_sum", 32'(out_sum), 32'(got.sum));
        chk("out_err", 32'(out_err), 32'(got.err));
        chk("out_retries", 32'(out_retries), 32'(got.retries));
        chk("latency", 32'(lat), 32'(got.lat));
        chk("err_count", 32'(err_count), 32'(exp_errcnt));
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sum", 32'(out_sum), 32'(got.sum));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("done_valid_before_hs", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int   seen;
        exp_t e;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
`ifdef ADDRU_FAULT_INJ_EN
        fi_mask = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_out_retries", 32'(out_retries), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 200+100 clean
        e = clean(8'd200, 8'd100);
        chk("model_300", 32'(e.sum), 32'h12C);
        run_txn(8'd200, 8'd100, 9'h0, 9'h0, 0, e);

        // 255+255 with consumer stalled 4 cycles
        run_txn(8'd255, 8'd255, 9'h0, 9'h0, 4, clean(8'd255, 8'd255));
        run_txn(8'd0, 8'd0, 9'h0, 9'h0, 0, clean(8'd0, 8'd0));
        run_txn(8'd255, 8'd0, 9'h0, 9'h0, 1, clean(8'd255, 8'd0));

`ifdef ADDRU_FAULT_INJ_EN
        // persistent single-bit fault: exhausts retries
        e.sum = 9'h12D; e.err = 1'b1; e.retries = 4'd2; e.lat = 7; e.mism = 3;
        run_txn(8'd200, 8'd100, 9'h001, 9'h001, 0, e);
        // transient fault on first compute only
        e.sum = 9'h12C; e.err = 1'b0; e.retries = 4'd1; e.lat = 5; e.mism = 1;
        run_txn(8'd200, 8'd100, 9'h004, 9'h000, 0, e);
        // error worth 3 is invisible to the residue check
        e.sum = 9'h12F; e.err = 1'b0; e.retries = 4'd0; e.lat = 3; e.mism = 0;
        run_txn(8'd200, 8'd100, 9'h003, 9'h003, 0, e);
        fi_mask = 9'h001;
`endif

        for (int n = 0; n < 20; n++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
`ifdef ADDRU_FAULT_INJ_EN
            fi_mask = '0;
`endif
            run_txn(ra, rb, 9'h0, 9'h0, n % 3, clean(ra, rb));
        end

        // reset while in CHECK discards the transaction
`ifdef ADDRU_FAULT_INJ_EN
        fi_mask = 9'h001;
`endif
        in_a = 8'd17; in_b = 8'd42; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_errcnt = 0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_err_count", 32'(err_count), 32'd0);
`ifdef ADDRU_FAULT_INJ_EN
        fi_mask = '0;
`endif
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort_no_output", 32'(seen), 32'd0);

        run_txn(8'd1, 8'd2, 9'h0, 9'h0, 0, clean(8'd1, 8'd2));
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
